p2p_result_collector: RTL
=========================

Name: p2p_result_collector

Overview:
- Downstream stage of the point-to-point matrix multiplier: captures the 16 element-wise products it emits, one per valid cycle.
- Buffers the products in a 16-entry register file and accumulates their running sum and maximum.
- Once full, drains the stored products in index order over a valid/ready stream to the result consumer.
- Flags completion and any product arriving while the buffer is not accepting.

Parameters:
- SIZE, 16, number of matrix elements per frame; must equal the multiplier's size.
- DW, 8, product width, matching the multiplier's 8-bit product output.
- AW, 4, index width, clog2(SIZE).
- SW, 12, sum width, DW + AW; holds SIZE*255 = 4080 without overflow.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  Reset is asynchronous and active-low: 0 clears all state immediately, independent of clk.
- clear  input  1  synchronous frame restart; returns to COLLECT with all counters and sum/max zeroed.
- in_valid  input  1  product on in_data is valid this cycle; driven by the integration logic alongside the multiplier output.
- in_data  input  DW  product value.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_valid  output  1  out_data/out_idx hold a stored product.
- out_data  output  DW  stored product at out_idx.
- out_idx  output  AW  element index of out_data.
- out_last  output  1  high with out_valid when out_idx == SIZE-1.
- sum  output  SW  running sum of accepted products.
- max_val  output  DW  largest accepted product.
- full  output  1  all SIZE products captured.
- done  output  1  drain complete.
- overflow_err  output  1  sticky; a product arrived while not in COLLECT.

Behaviour:
- Reset values: state=COLLECT; wr_ptr=0, rd_ptr=0; sum=0, max_val=0; full=0, done=0, overflow_err=0; out_valid=0. Buffer contents are don't-care.
- FSM states: COLLECT, DRAIN, DONE.
- COLLECT:
  - Each cycle with in_valid=1: buf[wr_ptr] <= in_data; sum <= sum + in_data (zero-extended to SW); max_val <= max(max_val, in_data); wr_ptr++.
  - sum/max_val reflect an accepted product one cycle after acceptance.
  - On the accept with wr_ptr == SIZE-1: wr_ptr wraps to 0, full <= 1, next state DRAIN.
- DRAIN:
  - out_valid=1, out_idx=rd_ptr, out_data=buf[rd_ptr].
  - out_data/out_idx are held stable while out_valid && !out_ready.
  - A transfer (out_valid && out_ready) advances rd_ptr.
  - Transfer with rd_ptr == SIZE-1: rd_ptr wraps to 0, done <= 1, next state DONE.
  - First out_valid appears the cycle after full rises.
- DONE:
  - out_valid=0. sum, max_val, full and done hold.
  - Leaves only on clear or reset.
- in_valid in DRAIN or DONE: sample is dropped, buffer/sum/max are unchanged, overflow_err <= 1 (sticky until clear or reset).
- clear has priority over every other event in any state:
  - Next cycle: COLLECT, pointers 0, sum/max 0, full/done/overflow_err 0.
  - in_valid coincident with clear is dropped and does not set overflow_err.
- out_ready while out_valid=0 is ignored.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is discarded.
- Arithmetic: unsigned throughout; sum cannot overflow SW for SIZE <= 16.

Decomposition:
- Shared package p2p_pkg: SIZE, DW, AW, SW constants and the state enum (COLLECT, DRAIN, DONE), also used by the multiplier integration.
- One natural sub-module, p2p_stat_acc: sum and max accumulator with clear and accept inputs.
- Buffer and FSM stay in the top module.

Test Plan:
- Reset then stream 1..16 with in_valid continuous -> full rises the cycle after the 16th accept; sum=136, max_val=16; drain with out_ready=1 gives out_data 1..16, out_idx 0..15, out_last only at idx 15; done=1 the cycle after.
- All products 0xFF -> sum=4080 (0xFF0), max_val=0xFF; no wrap of sum.
- Backpressure: during drain, toggle out_ready 1,0,0,1 -> each index transferred exactly once; out_data stable while stalled.
- in_valid=1 with in_data=0x55 during DRAIN -> overflow_err=1; sum and buffer unchanged; drained sequence intact.
- clear asserted at wr_ptr=7 together with in_valid -> next cycle sum=0, max_val=0, wr_ptr=0, overflow_err=0; the new frame of 16 collects correctly.
- rst driven low asynchronously mid-DRAIN (between clk edges) -> out_valid, full, done, sum drop to 0 without a clock edge; after release, COLLECT accepts a fresh frame.

Source files
------------

// File: rtl/p2p_pkg.sv
// Shared constants and FSM encoding for the point-to-point multiplier result path.
package p2p_pkg;
    localparam int SIZE = 16;
    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int SW   = DW + AW;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_t;
endpackage

// File: rtl/p2p_stat_acc.sv
// Running sum and maximum of the accepted products of one frame.
module p2p_stat_acc
    import p2p_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          accept,
    input  logic [DW-1:0] data,
    output logic [SW-1:0] sum,
    output logic [DW-1:0] max_val
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum     <= '0;
            max_val <= '0;
        end else if (clear) begin
            sum     <= '0;
            max_val <= '0;
        end else if (accept) begin
            sum <= sum + {{(SW-DW){1'b0}}, data};
            if (data > max_val)
                max_val <= data;
        end
    end
endmodule

// File: rtl/p2p_result_collector.sv
// Captures one frame of SIZE products, tracks sum/max, then drains them in index order.
module p2p_result_collector
    import p2p_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_last,
    output logic [SW-1:0] sum,
    output logic [DW-1:0] max_val,
    output logic          full,
    output logic          done,
    output logic          overflow_err
);
    localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] mem [SIZE];
    logic          accept;

    // A product coincident with clear belongs to neither frame and is dropped.
    assign accept = in_valid && !clear && (state == COLLECT);

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= COLLECT;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            full         <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            out_valid    <= 1'b0;
        end else if (clear) begin
            state        <= COLLECT;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            full         <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            if (in_valid && state != COLLECT)
                overflow_err <= 1'b1;
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        if (wr_ptr == LAST_IDX) begin
                            wr_ptr <= '0;
                            full   <= 1'b1;
                            state  <= DRAIN;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // out_valid rises one cycle after full, then follows the handshake.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        if (rd_ptr == LAST_IDX) begin
                            rd_ptr    <= '0;
                            done      <= 1'b1;
                            out_valid <= 1'b0;
                            state     <= DONE;
                        end else begin
                            rd_ptr <= rd_ptr + AW'(1);
                        end
                    end
                end
                DONE: ;
                default: state <= COLLECT;
            endcase
        end
    end

    assign out_data = mem[rd_ptr];
    assign out_idx  = rd_ptr;
    assign out_last = out_valid && (rd_ptr == LAST_IDX);

    p2p_stat_acc u_stat_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .accept  (accept),
        .data    (in_data),
        .sum     (sum),
        .max_val (max_val)
    );
endmodule
